// File: rtl/noc_pkg.sv
// Shared NoC types: flit type field, output port codes and route FSM states.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4,
        PORT_NONE  = 3'd7
    } port_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FWD  = 2'd2
    } route_state_e;

    // Type field bit positions, counted downwards from the flit MSB.
    localparam int FLIT_TYPE_MSB = 0;
    localparam int FLIT_TYPE_LSB = 1;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-ordered (X then Y) output port selection for one router.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int COORD_W = 2,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic [2*COORD_W-1:0] dest,
    output port_e                out_port
);

    localparam logic [COORD_W-1:0] HERE_X = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(LOCAL_Y);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    assign dx = dest[COORD_W-1:0];
    assign dy = dest[2*COORD_W-1:COORD_W];

    // X is resolved fully before Y is considered.
    always_comb begin
        if (dx > HERE_X)
            out_port = PORT_EAST;
        else if (dx < HERE_X)
            out_port = PORT_WEST;
        else if (dy > HERE_Y)
            out_port = PORT_NORTH;
        else if (dy < HERE_Y)
            out_port = PORT_SOUTH;
        else
            out_port = PORT_LOCAL;
    end

endmodule

// File: rtl/nexthop_route_unit.sv
// Per-input route unit: routes the head flit, writes the next-hop register, requests the
// arbiter, passes flits through to the crossbar until the tail and then releases the entry.
module nexthop_route_unit
    import noc_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int COORD_W = 2,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              flit_ready_o,
    output logic [2:0]        nhr_address_o,
    output logic              nhr_write_o,
    output logic              req_o,
    input  logic              grant_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    route_state_e state;
    flit_type_e   in_type;
    port_e        route;
    logic         first_done;
    logic         is_head;
    logic         fwd_grant;
    logic         idle_drop;
    logic         transfer;
    logic         ends_packet;

    assign in_type = flit_type_e'(flit_i[FLIT_W-1-FLIT_TYPE_MSB : FLIT_W-1-FLIT_TYPE_LSB]);
    assign is_head = (in_type == FLIT_HEAD) || (in_type == FLIT_SINGLE);

    xy_route_calc #(
        .COORD_W (COORD_W),
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) u_xy_route_calc (
        .dest     (flit_i[2*COORD_W-1:0]),
        .out_port (route)
    );

    // Handshakes are gated by reset so the outputs read idle for the whole reset pulse.
    assign fwd_grant    = (state == FWD) && grant_i && !reset;
    assign idle_drop    = (state == IDLE) && flit_valid_i && !is_head && !reset;
    assign flit_o       = flit_i;
    assign flit_valid_o = fwd_grant && flit_valid_i;
    assign flit_ready_o = (fwd_grant && flit_ready_i) || idle_drop;
    assign transfer     = fwd_grant && flit_valid_i && flit_ready_i;
    assign ends_packet  = (in_type == FLIT_TAIL) || ((in_type == FLIT_SINGLE) && !first_done);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            nhr_address_o <= PORT_NONE;
            nhr_write_o   <= 1'b0;
            req_o         <= 1'b0;
            err_o         <= 1'b0;
            first_done    <= 1'b0;
        end else begin
            nhr_write_o <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (flit_valid_i) begin
                        if (is_head) begin
                            nhr_address_o <= route;
                            nhr_write_o   <= 1'b1;
                            req_o         <= 1'b1;
                            first_done    <= 1'b0;
                            state         <= REQ;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (grant_i)
                        state <= FWD;
                end
                FWD: begin
                    // The head itself is the first transfer; any later head is a protocol error.
                    if (transfer) begin
                        first_done <= 1'b1;
                        if (is_head && first_done)
                            err_o <= 1'b1;
                        if (ends_packet) begin
                            nhr_address_o <= PORT_NONE;
                            nhr_write_o   <= 1'b1;
                            req_o         <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nexthop_route_unit.sv
// Directed bench for nexthop_route_unit on router (1,1) with hand-computed expectations.
module tb_nexthop_route_unit;
    import noc_pkg::*;

    localparam int FLIT_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [FLIT_W-1:0] flit_i = '0;
    logic              flit_valid_i = 1'b0;
    logic              flit_ready_o;
    logic [2:0]        nhr_address_o;
    logic              nhr_write_o;
    logic              req_o;
    logic              grant_i = 1'b0;
    logic [FLIT_W-1:0] flit_o;
    logic              flit_valid_o;
    logic              flit_ready_i = 1'b0;
    logic              busy_o;
    logic              err_o;

    logic [31:0] ctrlObs;
    logic [31:0] dataObs;
    logic [31:0] pkt [4];
    logic [31:0] f;
    int          checks = 0;
    int          errors = 0;
    int          idx;

    nexthop_route_unit #(
        .FLIT_W  (FLIT_W),
        .COORD_W (2),
        .LOCAL_X (1),
        .LOCAL_Y (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_i        (flit_i),
        .flit_valid_i  (flit_valid_i),
        .flit_ready_o  (flit_ready_o),
        .nhr_address_o (nhr_address_o),
        .nhr_write_o   (nhr_write_o),
        .req_o         (req_o),
        .grant_i       (grant_i),
        .flit_o        (flit_o),
        .flit_valid_o  (flit_valid_o),
        .flit_ready_i  (flit_ready_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    assign ctrlObs = {25'd0, nhr_write_o, nhr_address_o, req_o, busy_o, err_o};
    assign dataObs = {30'd0, flit_valid_o, flit_ready_o};

    function automatic logic [31:0] ctrlExp(logic w, logic [2:0] a, logic r, logic b, logic e);
        return {25'd0, w, a, r, b, e};
    endfunction

    function automatic logic [31:0] mkFlit(logic [1:0] t, logic [1:0] x, logic [1:0] y,
                                           logic [7:0] tag);
        return {t, 18'd0, tag, y, x};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] flit, input logic valid);
        flit_i       = flit;
        flit_valid_i = valid;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        waitCycle();
        waitCycle();
        checkOutput("reset ctrl", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b0));
        checkOutput("reset data", dataObs, 32'd0);
        reset = 1'b0;

        // HEAD to (3,1) -> EAST, then a TAIL
        f = mkFlit(FLIT_HEAD, 2'd3, 2'd1, 8'h11);
        applyStimulus(f, 1'b1);
        #1 checkOutput("t1 head peek", dataObs, 32'd0);
        waitCycle();
        checkOutput("t1 route write", ctrlObs, ctrlExp(1'b1, 3'd2, 1'b1, 1'b1, 1'b0));
        grant_i = 1'b1;
        flit_ready_i = 1'b1;
        #1 checkOutput("t1 req no xfer", dataObs, 32'd0);
        waitCycle();
        checkOutput("t1 fwd ctrl", ctrlObs, ctrlExp(1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
        checkOutput("t1 fwd hs", dataObs, 32'd3);
        checkOutput("t1 head out", flit_o, f);
        waitCycle();
        f = mkFlit(FLIT_TAIL, 2'd0, 2'd0, 8'h12);
        applyStimulus(f, 1'b1);
        #1 checkOutput("t1 tail out", flit_o, f);
        checkOutput("t1 tail hs", dataObs, 32'd3);
        waitCycle();
        applyStimulus(32'd0, 1'b0);
        grant_i = 1'b0;
        checkOutput("t1 release", ctrlObs, ctrlExp(1'b1, 3'd7, 1'b0, 1'b0, 1'b0));
        waitCycle();
        checkOutput("t1 write pulse", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b0));

        // Stray BODY in IDLE is dropped with an error pulse
        applyStimulus(mkFlit(FLIT_BODY, 2'd0, 2'd0, 8'h40), 1'b1);
        #1 checkOutput("t4 drop ready", dataObs, 32'd1);
        waitCycle();
        applyStimulus(32'd0, 1'b0);
        checkOutput("t4 err pulse", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b1));
        waitCycle();
        checkOutput("t4 err clear", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b0));

        // Four-flit packet to (1,0) -> SOUTH, late grant, toggling downstream ready
        pkt[0] = mkFlit(FLIT_HEAD, 2'd1, 2'd0, 8'h21);
        pkt[1] = mkFlit(FLIT_BODY, 2'd0, 2'd0, 8'h22);
        pkt[2] = mkFlit(FLIT_BODY, 2'd0, 2'd0, 8'h23);
        pkt[3] = mkFlit(FLIT_TAIL, 2'd0, 2'd0, 8'h24);
        applyStimulus(pkt[0], 1'b1);
        flit_ready_i = 1'b1;
        waitCycle();
        checkOutput("t2 route write", ctrlObs, ctrlExp(1'b1, 3'd3, 1'b1, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("t2 wait grant", dataObs, 32'd0);
            waitCycle();
        end
        grant_i = 1'b1;
        waitCycle();
        idx = 0;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            flit_ready_i = (c % 2 == 0);
            applyStimulus(pkt[idx], 1'b1);
            #1 checkOutput("t2 flit order", flit_o, pkt[idx]);
            checkOutput("t2 hs", dataObs, {30'd0, 1'b1, flit_ready_i});
            waitCycle();
            if (flit_ready_i)
                idx++;
        end
        applyStimulus(32'd0, 1'b0);
        checkOutput("t2 flit count", 32'(idx), 32'd4);
        checkOutput("t2 release", ctrlObs, ctrlExp(1'b1, 3'd7, 1'b0, 1'b0, 1'b0));
        grant_i = 1'b0;
        flit_ready_i = 1'b1;
        waitCycle();

        // Grant withdrawn for two cycles mid-packet, to (1,3) -> NORTH
        applyStimulus(mkFlit(FLIT_HEAD, 2'd1, 2'd3, 8'h51), 1'b1);
        grant_i = 1'b1;
        waitCycle();
        checkOutput("t5 route write", ctrlObs, ctrlExp(1'b1, 3'd1, 1'b1, 1'b1, 1'b0));
        waitCycle();
        checkOutput("t5 head hs", dataObs, 32'd3);
        waitCycle();
        f = mkFlit(FLIT_BODY, 2'd0, 2'd0, 8'h52);
        applyStimulus(f, 1'b1);
        grant_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 checkOutput("t5 stall hs", dataObs, 32'd0);
            checkOutput("t5 stall ctrl", ctrlObs, ctrlExp(1'b0, 3'd1, 1'b1, 1'b1, 1'b0));
            waitCycle();
        end
        grant_i = 1'b1;
        #1 checkOutput("t5 body kept", flit_o, f);
        checkOutput("t5 resume hs", dataObs, 32'd3);
        waitCycle();
        f = mkFlit(FLIT_TAIL, 2'd0, 2'd0, 8'h53);
        applyStimulus(f, 1'b1);
        #1 checkOutput("t5 tail out", flit_o, f);
        waitCycle();
        applyStimulus(32'd0, 1'b0);
        checkOutput("t5 release", ctrlObs, ctrlExp(1'b1, 3'd7, 1'b0, 1'b0, 1'b0));
        waitCycle();

        // SINGLE to (1,1) -> LOCAL, then back-to-back HEAD to (0,1) -> WEST
        f = mkFlit(FLIT_SINGLE, 2'd1, 2'd1, 8'h31);
        applyStimulus(f, 1'b1);
        waitCycle();
        checkOutput("t3 route write", ctrlObs, ctrlExp(1'b1, 3'd0, 1'b1, 1'b1, 1'b0));
        waitCycle();
        checkOutput("t3 single out", flit_o, f);
        checkOutput("t3 single hs", dataObs, 32'd3);
        waitCycle();
        applyStimulus(mkFlit(FLIT_HEAD, 2'd0, 2'd1, 8'h61), 1'b1);
        #1 checkOutput("t3 release", ctrlObs, ctrlExp(1'b1, 3'd7, 1'b0, 1'b0, 1'b0));
        checkOutput("t3 next head peek", dataObs, 32'd0);
        waitCycle();
        checkOutput("b2b route write", ctrlObs, ctrlExp(1'b1, 3'd4, 1'b1, 1'b1, 1'b0));
        waitCycle();
        checkOutput("b2b fwd hs", dataObs, 32'd3);

        // Asynchronous reset in the middle of a FWD cycle
        #3 reset = 1'b1;
        #1 checkOutput("async reset ctrl", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b0));
        checkOutput("async reset data", dataObs, 32'd0);
        waitCycle();
        reset = 1'b0;
        #1 checkOutput("post reset idle", ctrlObs, ctrlExp(1'b0, 3'd7, 1'b0, 1'b0, 1'b0));
        waitCycle();
        checkOutput("post reset route", ctrlObs, ctrlExp(1'b1, 3'd4, 1'b1, 1'b1, 1'b0));

        applyStimulus(32'd0, 1'b0);
        grant_i = 1'b0;
        waitCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
